// File: rtl/metric_pkg.sv
// Shared types and constants for the metric max-reduction sequencer.
package metric_pkg;

    localparam int METRIC_W  = 16;
    localparam int METRIC_N  = 8;
    localparam int METRIC_IW = $clog2(METRIC_N);

    typedef logic signed [METRIC_W-1:0] metric_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam metric_t METRIC_MIN = {1'b1, {(METRIC_W-1){1'b0}}};
    localparam metric_t METRIC_MAX = {1'b0, {(METRIC_W-1){1'b1}}};

endpackage

// File: rtl/metric_max2.sv
// Combinational signed compare/select: gt_o = (a_i > b_i), max_o = larger operand (b_i on ties).
module metric_max2
    import metric_pkg::*;
#(
    parameter int W = METRIC_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic                gt_o,
    output logic signed [W-1:0] max_o
);

    // One guard bit makes the difference exact, so its sign is the true ordering.
    logic signed [W:0] diff;

    assign diff  = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    assign gt_o  = !diff[W] && (diff != '0);
    assign max_o = gt_o ? a_i : b_i;

endmodule

// File: rtl/metric_max_sched.sv
// Time-shared max/argmax over N signed metrics using one comparator.
// Optional normalised output vector when METRIC_NORM_EN is defined.
module metric_max_sched
    import metric_pkg::*;
#(
    parameter  int N  = METRIC_N,
    parameter  int W  = METRIC_W,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] metrics_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   max_out,
    output logic [IW-1:0]  max_idx
`ifdef METRIC_NORM_EN
   ,output logic [N*W-1:0] norm_out
`endif
);

    state_e              state_q, state_d;
    logic signed [W-1:0] vec_q [N];
    logic signed [W-1:0] vec_d [N];
    logic signed [W-1:0] acc_q, acc_d;
    logic [IW-1:0]       acc_idx_q, acc_idx_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        max_q, max_d;
    logic [IW-1:0]       max_idx_q, max_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic signed [W-1:0] cand, sel;
    logic                gt;
    logic                commit;

    // cnt wraps to 0 after the last slot; SCAN with cnt=0 is the commit cycle.
    assign commit = (state_q == SCAN) && (cnt_q == '0);
    assign cand   = vec_q[cnt_q];

    metric_max2 #(.W(W)) u_max2 (
        .a_i   (cand),
        .b_i   (acc_q),
        .gt_o  (gt),
        .max_o (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks keep every register updating from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: assigning a default first guarantees no latch on any path through the case.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)  state_d = SCAN;
            SCAN:    if (commit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_comb begin
        vec_d     = vec_q;
        acc_d     = acc_q;
        acc_idx_d = acc_idx_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        case (state_q)
            IDLE: if (start) begin
                for (int k = 0; k < N; k++) vec_d[k] = metrics_in[k*W +: W];
                acc_d     = metrics_in[W-1:0];
                acc_idx_d = '0;
                cnt_d     = IW'(1);
            end
            SCAN: if (commit) begin
                max_d     = acc_q;
                max_idx_d = acc_idx_q;
            end else begin
                acc_d = sel;
                if (gt) acc_idx_d = cnt_q;
                cnt_d = (cnt_q == IW'(N-1)) ? '0 : cnt_q + IW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured vector is reset too, so no stale metrics survive a reset.
            for (int k = 0; k < N; k++) vec_q[k] <= '0;
            acc_q     <= '0;
            acc_idx_q <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            acc_q     <= acc_d;
            acc_idx_q <= acc_idx_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign max_out = max_q;
    assign max_idx = max_idx_q;

`ifdef METRIC_NORM_EN
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [N*W-1:0] norm_q, norm_d;

    // Difference is never positive, so only negative overflow needs clamping.
    function automatic logic [W-1:0] sat_sub(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [W:0] d;
        d = {a[W-1], a} - {b[W-1], b};
        return (d[W] != d[W-1]) ? SAT_MIN : d[W-1:0];
    endfunction

    always_comb begin
        norm_d = norm_q;
        if (commit) begin
            for (int k = 0; k < N; k++) norm_d[k*W +: W] = sat_sub(vec_q[k], acc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) norm_q <= '0;
        else        norm_q <= norm_d;
    end

    assign norm_out = norm_q;
`endif

endmodule

// File: tb/tb_metric_max_sched.sv
// Randomised and directed bench for metric_max_sched against a behavioural max/argmax model.
module tb_metric_max_sched;
    import metric_pkg::*;

    localparam int N    = METRIC_N;
    localparam int W    = METRIC_W;
    localparam int IW   = METRIC_IW;
    localparam int MINV = -(2 ** (W - 1));

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] metrics_in = '0;
    logic           busy, done;
    logic [W-1:0]   max_out;
    logic [IW-1:0]  max_idx;
`ifdef METRIC_NORM_EN
    logic [N*W-1:0] norm_out;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    metric_max_sched #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .metrics_in (metrics_in),
        .busy       (busy),
        .done       (done),
        .max_out    (max_out),
        .max_idx    (max_idx)
`ifdef METRIC_NORM_EN
       ,.norm_out   (norm_out)
`endif
    );

    function automatic logic [N*W-1:0] pack(input int a [N]);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(a[k]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0:       r[k*W +: W] = METRIC_MIN;
                1:       r[k*W +: W] = METRIC_MAX;
                2:       r[k*W +: W] = W'(int'($urandom_range(0, 6)) - 3);
                default: r[k*W +: W] = W'($urandom);
            endcase
        end
        return r;
    endfunction

    // Reference: first strictly larger element wins, so ties keep the lowest index.
    function automatic void ref_max(input logic [N*W-1:0] v, output int mx, output int idx);
        int m;
        mx  = $signed(v[W-1:0]);
        idx = 0;
        for (int k = 1; k < N; k++) begin
            m = $signed(v[k*W +: W]);
            if (m > mx) begin
                mx  = m;
                idx = k;
            end
        end
    endfunction

`ifdef METRIC_NORM_EN
    function automatic logic [N*W-1:0] ref_norm(input logic [N*W-1:0] v, input int mx);
        logic [N*W-1:0] r;
        int d;
        for (int k = 0; k < N; k++) begin
            d = int'($signed(v[k*W +: W])) - mx;
            if (d < MINV) d = MINV;
            r[k*W +: W] = W'(d);
        end
        return r;
    endfunction
`endif

    // One accepted reduction: start at edge E, done expected only in cycle k=N after E.
    task automatic do_run(input logic [N*W-1:0] v, input string name);
        int             mx, idx, done_at, done_cnt;
        bit             busy_ok;
        logic [W-1:0]   got_max;
        logic [IW-1:0]  got_idx;
`ifdef METRIC_NORM_EN
        logic [N*W-1:0] got_norm;
        got_norm = 'x;
`endif
        ref_max(v, mx, idx);
        got_max  = 'x;
        got_idx  = 'x;
        done_at  = -1;
        done_cnt = 0;
        busy_ok  = 1'b1;
        @(negedge clk);
        start      = 1'b1;
        metrics_in = v;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start      = 1'b0;
                metrics_in = rand_vec();
            end
            if (busy !== (k <= N)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    got_max = max_out;
                    got_idx = max_idx;
`ifdef METRIC_NORM_EN
                    got_norm = norm_out;
`endif
                end
            end
        end
        checks++;
        if (done_at != N || done_cnt != 1)
            begin errors++; $display("FAIL %s done_timing: first at cycle %0d count %0d, expected cycle %0d count 1", name, done_at, done_cnt, N); end
        checks++;
        if (!busy_ok)
            begin errors++; $display("FAIL %s busy_window: busy not high exactly for cycles 0..%0d", name, N); end
        checks++;
        if (got_max !== W'(mx))
            begin errors++; $display("FAIL %s max_out: got %0d expected %0d", name, $signed(got_max), mx); end
        checks++;
        if (got_idx !== IW'(idx))
            begin errors++; $display("FAIL %s max_idx: got %0d expected %0d", name, got_idx, idx); end
        checks++;
        if (max_out !== W'(mx))
            begin errors++; $display("FAIL %s max_out_held: got %0d expected %0d", name, $signed(max_out), mx); end
`ifdef METRIC_NORM_EN
        checks++;
        if (got_norm !== ref_norm(v, mx))
            begin errors++; $display("FAIL %s norm_out: got %h expected %h", name, got_norm, ref_norm(v, mx)); end
`endif
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL %s flags: busy=%b done=%b expected 0 0", name, busy, done); end
        checks++;
        if (max_out !== '0 || max_idx !== '0)
            begin errors++; $display("FAIL %s result: max_out=%0d max_idx=%0d expected 0 0", name, $signed(max_out), max_idx); end
`ifdef METRIC_NORM_EN
        checks++;
        if (norm_out !== '0)
            begin errors++; $display("FAIL %s norm_out: got %h expected 0", name, norm_out); end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("after_release");
    endtask

    task automatic test_directed();
        int a [N] = '{3, -7, 12, 5, 12, 0, -1, 9};
        do_run(pack(a), "directed_tie");
    endtask

    task automatic test_extremes();
        int a [N];
        for (int k = 0; k < N; k++) a[k] = MINV;
        a[1] = int'(METRIC_MAX);
        do_run(pack(a), "max_vs_min");
        for (int k = 0; k < N; k++) a[k] = MINV;
        do_run(pack(a), "all_min");
        for (int k = 0; k < N; k++) a[k] = 0;
        a[0] = int'(METRIC_MAX);
        a[1] = MINV;
        do_run(pack(a), "norm_saturate");
    endtask

    task automatic test_last_slot();
        int a [N];
        for (int k = 0; k < N; k++) a[k] = 0;
        a[N-1] = 1;
        do_run(pack(a), "last_slot");
        do_run(rand_vec(), "after_wrap");
    endtask

    // start held high while metrics_in churns; second accept is in the idle cycle after done.
    task automatic test_protocol();
        logic [N*W-1:0] v1, v2;
        int             mx1, idx1, mx2, idx2, done_cnt;
        int             done_k [2];
        logic [W-1:0]   got_max [2];
        logic [IW-1:0]  got_idx [2];
        bit             gap_ok;
        v1 = rand_vec();
        v2 = rand_vec();
        ref_max(v1, mx1, idx1);
        ref_max(v2, mx2, idx2);
        done_cnt = 0;
        gap_ok   = 1'b1;
        done_k   = '{-1, -1};
        got_max  = '{'x, 'x};
        got_idx  = '{'x, 'x};
        @(negedge clk);
        start      = 1'b1;
        metrics_in = v1;
        @(posedge clk);
        for (int k = 0; k < 2 * N + 6; k++) begin
            @(negedge clk);
            metrics_in = (k == N + 1) ? v2 : rand_vec();
            if (k == 2 * N + 3) start = 1'b0;
            if (k == N + 1 && busy !== 1'b0) gap_ok = 1'b0;
            if (k == N + 2 && busy !== 1'b1) gap_ok = 1'b0;
            if (done === 1'b1) begin
                if (done_cnt < 2) begin
                    done_k[done_cnt]  = k;
                    got_max[done_cnt] = max_out;
                    got_idx[done_cnt] = max_idx;
                end
                done_cnt++;
            end
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 2 || done_k[0] != N || done_k[1] != 2 * N + 2)
            begin errors++; $display("FAIL protocol done_pulses: count %0d at %0d,%0d expected 2 at %0d,%0d", done_cnt, done_k[0], done_k[1], N, 2 * N + 2); end
        checks++;
        if (!gap_ok)
            begin errors++; $display("FAIL protocol idle_gap: busy not low at cycle %0d and high at cycle %0d", N + 1, N + 2); end
        checks++;
        if (got_max[0] !== W'(mx1) || got_idx[0] !== IW'(idx1))
            begin errors++; $display("FAIL protocol first_result: got %0d@%0d expected %0d@%0d", $signed(got_max[0]), got_idx[0], mx1, idx1); end
        checks++;
        if (got_max[1] !== W'(mx2) || got_idx[1] !== IW'(idx2))
            begin errors++; $display("FAIL protocol second_result: got %0d@%0d expected %0d@%0d", $signed(got_max[1]), got_idx[1], mx2, idx2); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) do_run(rand_vec(), $sformatf("random_%0d", r));
    endtask

    task automatic test_reset_mid();
        int  a [N] = '{1, 2, 3, 40, 5, 6, 7, 8};
        int  spurious;
        do_run(pack(a), "pre_reset");
        @(negedge clk);
        start      = 1'b1;
        metrics_in = rand_vec();
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0)
            begin errors++; $display("FAIL reset_mid no_pulse: %0d cycles with busy/done after release, expected 0", spurious); end
        do_run(rand_vec(), "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_extremes();
        test_last_slot();
        test_protocol();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
